// File: rtl/temp_report_framer_if.sv
// Byte-stream link from the temperature report framer
// towards the TX FIFO / UART path.
interface temp_report_framer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/temp_report_framer.sv
// Temperature sample to ASCII report framer ("temp:-25.37\r\n")
// using a sequential double-dabble binary-to-BCD converter.
module temp_report_framer #(
    parameter int REPORT_CYC  = 50000000,
    parameter int DATA_W      = 14,
    parameter int INT_DIGITS  = 3,
    parameter int FRAC_DIGITS = 2,
    parameter bit LZ_SUPPRESS = 1'b1,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] temp_data,
    input  logic              temp_sign,
    input  logic              temp_valid,
    input  logic              trig,
    temp_report_framer_if.master tx,
    output logic              busy,
    output logic              frame_done,
    output logic              sat,
    output logic              trig_drop
);

    localparam int D  = INT_DIGITS + FRAC_DIGITS;
    localparam int BW = 4 * D;
    localparam int TW = (REPORT_CYC > 1) ? $clog2(REPORT_CYC) : 1;
    localparam int CW = $clog2(DATA_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT      = pow10(D);
    localparam logic [2:0]  LAST_INT   = 3'(INT_DIGITS - 1);
    localparam logic [2:0]  FIRST_FRAC = 3'(INT_DIGITS);
    localparam logic [2:0]  LAST_DIG   = 3'(D - 1);
    localparam logic [39:0] PRE_STR    = 40'h74656D703A;

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_PRE, S_SIGN,
        S_INT, S_DOT, S_FRAC, S_EOL
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [TW-1:0]     tmr_q;
    logic [DATA_W-1:0] held_q;
    logic              hsign_q;
    logic [DATA_W-1:0] sh_q;
    logic              sign_q;
    logic [BW-1:0]     bcd_q;
    logic [CW-1:0]     cyc_q;
    logic              ovf_q;

    logic          tick;
    logic          trig_any;
    logic          start;
    logic          conv_last;
    logic          emit;
    logic          xfer;
    logic          last_b;
    logic [2:0]    first_int;
    logic [BW-1:0] adj;
    logic [BW-1:0] dd_next;
    logic [31:0]   bpad;
    logic [7:0]    data_c;

    assign tick      = (tmr_q == TW'(REPORT_CYC - 1));
    assign trig_any  = trig | tick;
    assign start     = (state_q == S_IDLE) && (trig_any || pend_q);
    assign conv_last = (state_q == S_CONV) &&
                       (cyc_q == CW'(DATA_W - 1));
    assign emit      = state_q inside {S_PRE, S_SIGN, S_INT,
                                       S_DOT, S_FRAC, S_EOL};
    assign xfer      = emit & tx.byte_ready;
    assign bpad      = {bcd_q, {(32 - BW){1'b0}}};
    assign dd_next   = {adj[BW-2:0], sh_q[DATA_W-1]};

    // Free-running report period timer, wraps into an internal trigger
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) tmr_q <= '0;
        else         tmr_q <= tick ? '0 : tmr_q + 1'b1;
    end

    // Held sample tracks every strobe, even while a frame is running
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            held_q  <= '0;
            hsign_q <= 1'b0;
        end else if (temp_valid) begin
            held_q  <= temp_data;
            hsign_q <= temp_sign;
        end
    end

    // Add-3 correction on every BCD digit ahead of the shift
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < D; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Snapshot on CONV entry, then one double-dabble step per cycle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sh_q   <= '0;
            sign_q <= 1'b0;
            bcd_q  <= '0;
            cyc_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (start) begin
            sh_q   <= held_q;
            sign_q <= hsign_q;
            bcd_q  <= '0;
            cyc_q  <= '0;
            ovf_q  <= (64'(held_q) >= LIMIT);
        end else if (state_q == S_CONV) begin
            sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
            cyc_q <= cyc_q + 1'b1;
            bcd_q <= (conv_last && ovf_q) ? {D{4'h9}} : dd_next;
        end
    end

    // First integer digit to print when leading zeros are dropped
    always_comb begin
        first_int = LZ_SUPPRESS ? LAST_INT : 3'd0;
        if (LZ_SUPPRESS) begin
            for (int i = INT_DIGITS - 2; i >= 0; i--) begin
                if (bpad[31-4*i -: 4] != 4'd0)
                    first_int = 3'(i);
            end
        end
    end

    // FSM state, digit index and pending-trigger registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Frame sequencing; byte states advance only on a transfer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        last_b  = 1'b0;
        if (state_q == S_IDLE) pend_d = 1'b0;
        else if (trig_any)     pend_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CONV;
            end
            S_CONV: begin
                if (conv_last) begin
                    state_d = S_PRE;
                    idx_d   = '0;
                end
            end
            S_PRE: begin
                if (xfer) begin
                    if (idx_q == 3'd4) begin
                        state_d = sign_q ? S_SIGN : S_INT;
                        idx_d   = first_int;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_SIGN: begin
                if (xfer) begin
                    state_d = S_INT;
                    idx_d   = first_int;
                end
            end
            S_INT: begin
                if (xfer) begin
                    if (idx_q != LAST_INT) begin
                        idx_d = idx_q + 3'd1;
                    end else if (FRAC_DIGITS > 0) begin
                        state_d = S_DOT;
                    end else if (APPEND_CRLF) begin
                        state_d = S_EOL;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        last_b  = 1'b1;
                    end
                end
            end
            S_DOT: begin
                if (xfer) begin
                    state_d = S_FRAC;
                    idx_d   = FIRST_FRAC;
                end
            end
            S_FRAC: begin
                if (xfer) begin
                    if (idx_q != LAST_DIG) begin
                        idx_d = idx_q + 3'd1;
                    end else if (APPEND_CRLF) begin
                        state_d = S_EOL;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        last_b  = 1'b1;
                    end
                end
            end
            S_EOL: begin
                if (xfer) begin
                    if (idx_q == 3'd1) begin
                        state_d = S_IDLE;
                        last_b  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte selection and status pulses, all from registered state
    always_comb begin
        data_c = 8'h00;
        unique case (state_q)
            S_PRE:  data_c = PRE_STR[6'd39 - {idx_q, 3'b000} -: 8];
            S_SIGN: data_c = 8'h2D;
            S_INT,
            S_FRAC: data_c = {4'h3,
                              bpad[5'd31 - {idx_q, 2'b00} -: 4]};
            S_DOT:  data_c = 8'h2E;
            S_EOL:  data_c = (idx_q == 3'd0) ? 8'h0D : 8'h0A;
            default: data_c = 8'h00;
        endcase
        busy       = (state_q != S_IDLE);
        frame_done = last_b;
        sat        = conv_last && ovf_q;
        trig_drop  = trig_any && (state_q != S_IDLE) && pend_q;
    end

    assign tx.byte_data  = data_c;
    assign tx.byte_valid = emit;

endmodule

// File: tb/tb_temp_report_framer.sv
// Directed bench for temp_report_framer across several
// parameter sets sharing one stimulus stream.
module tb_temp_report_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] td;
    logic        ts, tv, tg, br;

    logic [7:0] bd  [5];
    logic       bv  [5];
    logic       bsy [5];
    logic       fd  [5];
    logic       st  [5];
    logic       dr  [5];

    string s     [5];
    int    rise  [5][4];
    int    nrise [5];
    int    ndone [5];
    int    lastd [5];
    int    nsat  [5];
    int    satc  [5];
    int    ndrop [5];
    int    unst  [5];
    bit    btr   [0:1023];

    int checks = 0;
    int errors = 0;

    localparam string CRLF = "\015\012";

    always #5 clk = ~clk;

    temp_report_framer_if tx0 ();
    temp_report_framer_if tx1 ();
    temp_report_framer_if tx2 ();
    temp_report_framer_if tx3 ();
    temp_report_framer_if tx4 ();

    assign tx0.byte_ready = br;
    assign tx1.byte_ready = br;
    assign tx2.byte_ready = br;
    assign tx3.byte_ready = br;
    assign tx4.byte_ready = br;
    assign bd[0] = tx0.byte_data;
    assign bd[1] = tx1.byte_data;
    assign bd[2] = tx2.byte_data;
    assign bd[3] = tx3.byte_data;
    assign bd[4] = tx4.byte_data;
    assign bv[0] = tx0.byte_valid;
    assign bv[1] = tx1.byte_valid;
    assign bv[2] = tx2.byte_valid;
    assign bv[3] = tx3.byte_valid;
    assign bv[4] = tx4.byte_valid;

    temp_report_framer u0 (
        .sys_clk(clk), .sys_rst(rst), .temp_data(td),
        .temp_sign(ts), .temp_valid(tv), .trig(tg),
        .tx(tx0), .busy(bsy[0]), .frame_done(fd[0]),
        .sat(st[0]), .trig_drop(dr[0]));

    temp_report_framer #(.LZ_SUPPRESS(1'b0)) u1 (
        .sys_clk(clk), .sys_rst(rst), .temp_data(td),
        .temp_sign(ts), .temp_valid(tv), .trig(tg),
        .tx(tx1), .busy(bsy[1]), .frame_done(fd[1]),
        .sat(st[1]), .trig_drop(dr[1]));

    temp_report_framer #(.INT_DIGITS(2)) u2 (
        .sys_clk(clk), .sys_rst(rst), .temp_data(td),
        .temp_sign(ts), .temp_valid(tv), .trig(tg),
        .tx(tx2), .busy(bsy[2]), .frame_done(fd[2]),
        .sat(st[2]), .trig_drop(dr[2]));

    temp_report_framer #(
        .FRAC_DIGITS(0), .APPEND_CRLF(1'b0)) u3 (
        .sys_clk(clk), .sys_rst(rst), .temp_data(td),
        .temp_sign(ts), .temp_valid(tv), .trig(tg),
        .tx(tx3), .busy(bsy[3]), .frame_done(fd[3]),
        .sat(st[3]), .trig_drop(dr[3]));

    temp_report_framer #(.REPORT_CYC(200)) u4 (
        .sys_clk(clk), .sys_rst(rst), .temp_data(td),
        .temp_sign(ts), .temp_valid(tv), .trig(1'b0),
        .tx(tx4), .busy(bsy[4]), .frame_done(fd[4]),
        .sat(st[4]), .trig_drop(dr[4]));

    function automatic string vis(input string x);
        string r;
        r = "";
        for (int i = 0; i < x.len(); i++) begin
            if (x[i] < 8'd32) r = {r, "~"};
            else              r = {r, $sformatf("%c", x[i])};
        end
        return r;
    endfunction

    task automatic load(input logic [13:0] d, input logic sg);
        @(negedge clk);
        td = d;
        ts = sg;
        tv = 1'b1;
        tg = 1'b0;
        @(negedge clk);
        tv = 1'b0;
    endtask

    // Run n cycles, recording bytes and pulses per instance
    task automatic run_cycles(
        input int n, input bit stall,
        input int ta, input int tb2, input int tc,
        input int tvc, input logic [13:0] tvd);
        bit         pv  [5];
        bit         pst [5];
        logic [7:0] pbd [5];
        for (int k = 0; k < 5; k++) begin
            s[k] = "";
            nrise[k] = 0; ndone[k] = 0; lastd[k] = -1;
            nsat[k] = 0; satc[k] = -1; ndrop[k] = 0;
            unst[k] = 0;
            for (int j = 0; j < 4; j++) rise[k][j] = -1;
            pv[k] = 1'b1; pst[k] = 1'b0; pbd[k] = 8'h00;
        end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tg = (c == ta) || (c == tb2) || (c == tc);
            tv = (c == tvc);
            if (c == tvc) td = tvd;
            br = stall ? (c % 3 == 2) : 1'b1;
            #1;
            if (c < 1024) btr[c] = bsy[0];
            for (int k = 0; k < 5; k++) begin
                if (bv[k] && !pv[k]) begin
                    if (nrise[k] < 4) rise[k][nrise[k]] = c;
                    nrise[k]++;
                end
                if (pst[k] && !(bv[k] && bd[k] == pbd[k]))
                    unst[k]++;
                if (bv[k] && br)
                    s[k] = {s[k], $sformatf("%c", bd[k])};
                if (fd[k]) begin ndone[k]++; lastd[k] = c; end
                if (st[k]) begin nsat[k]++; satc[k] = c; end
                if (dr[k]) ndrop[k]++;
                pv[k]  = bv[k];
                pst[k] = bv[k] && !br;
                pbd[k] = bd[k];
            end
        end
        @(negedge clk);
        tg = 1'b0;
        tv = 1'b0;
        br = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bv[k], bsy[k], fd[k], st[k], dr[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags inst %0d got %b exp 00000",
                    k, {bv[k], bsy[k], fd[k], st[k], dr[k]});
            end
            checks++;
            if (bd[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_data inst %0d got %h exp 00",
                    k, bd[k]);
            end
        end
    endtask

    task automatic test_default;
        string e;
        e = {"temp:25.37", CRLF};
        load(14'd2537, 1'b0);
        run_cycles(40, 1'b0, 0, -1, -1, -1, 14'd0);
        checks++;
        if (s[0] != e) begin
            errors++;
            $display("FAIL default_str got %s exp %s",
                vis(s[0]), vis(e));
        end
        checks++;
        if (rise[0][0] !== 15) begin
            errors++;
            $display("FAIL default_latency got %0d exp 15", rise[0][0]);
        end
        checks++;
        if (lastd[0] !== 26 || ndone[0] !== 1) begin
            errors++;
            $display("FAIL default_done got c%0d n%0d exp c26 n1",
                lastd[0], ndone[0]);
        end
        checks++;
        if (btr[26] !== 1'b1 || btr[27] !== 1'b0) begin
            errors++;
            $display("FAIL default_busy got %b%b exp 10",
                btr[26], btr[27]);
        end
        checks++;
        if (nsat[0] !== 0) begin
            errors++;
            $display("FAIL default_sat got %0d exp 0", nsat[0]);
        end
    endtask

    task automatic test_negative;
        string e0, e1;
        e0 = {"temp:-0.05", CRLF};
        e1 = {"temp:-000.05", CRLF};
        load(14'd5, 1'b1);
        run_cycles(40, 1'b0, 0, -1, -1, -1, 14'd0);
        checks++;
        if (s[0] != e0) begin
            errors++;
            $display("FAIL neg_lz got %s exp %s", vis(s[0]), vis(e0));
        end
        checks++;
        if (s[1] != e1) begin
            errors++;
            $display("FAIL neg_nolz got %s exp %s", vis(s[1]), vis(e1));
        end
    endtask

    task automatic test_saturate;
        string e0, e2;
        e0 = {"temp:163.83", CRLF};
        e2 = {"temp:99.99", CRLF};
        load(14'd16383, 1'b0);
        run_cycles(40, 1'b0, 0, -1, -1, -1, 14'd0);
        checks++;
        if (s[2] != e2) begin
            errors++;
            $display("FAIL sat_str got %s exp %s", vis(s[2]), vis(e2));
        end
        checks++;
        if (nsat[2] !== 1 || satc[2] !== 14) begin
            errors++;
            $display("FAIL sat_pulse got n%0d c%0d exp n1 c14",
                nsat[2], satc[2]);
        end
        checks++;
        if (s[0] != e0 || nsat[0] !== 0) begin
            errors++;
            $display("FAIL sat_wide got %s n%0d exp %s n0",
                vis(s[0]), nsat[0], vis(e0));
        end
        checks++;
        if (s[3] != "temp:999") begin
            errors++;
            $display("FAIL sat_int3 got %s exp temp:999", vis(s[3]));
        end
    endtask

    task automatic test_no_frac;
        string e0;
        e0 = {"temp:0.42", CRLF};
        load(14'd42, 1'b0);
        run_cycles(40, 1'b0, 0, -1, -1, -1, 14'd0);
        checks++;
        if (s[3] != "temp:42") begin
            errors++;
            $display("FAIL nofrac_str got %s exp temp:42", vis(s[3]));
        end
        checks++;
        if (lastd[3] !== 21 || ndone[3] !== 1) begin
            errors++;
            $display("FAIL nofrac_done got c%0d n%0d exp c21 n1",
                lastd[3], ndone[3]);
        end
        checks++;
        if (s[0] != e0) begin
            errors++;
            $display("FAIL frac_lz got %s exp %s", vis(s[0]), vis(e0));
        end
    endtask

    task automatic test_stall;
        string e0, e1;
        e0 = {"temp:25.37", CRLF};
        e1 = {"temp:025.37", CRLF};
        load(14'd2537, 1'b0);
        run_cycles(70, 1'b1, 0, -1, -1, -1, 14'd0);
        checks++;
        if (s[0] != e0 || s[1] != e1) begin
            errors++;
            $display("FAIL stall_str got %s / %s exp %s / %s",
                vis(s[0]), vis(s[1]), vis(e0), vis(e1));
        end
        checks++;
        if (unst[0] !== 0 || unst[1] !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d/%0d exp 0/0",
                unst[0], unst[1]);
        end
        checks++;
        if (ndone[0] !== 1 || rise[0][0] !== 15) begin
            errors++;
            $display("FAIL stall_frame got n%0d r%0d exp n1 r15",
                ndone[0], rise[0][0]);
        end
    endtask

    task automatic test_back_to_back;
        string e;
        e = {"temp:25.37", CRLF, "temp:1.00", CRLF};
        load(14'd2537, 1'b0);
        run_cycles(70, 1'b0, 0, 3, 20, 5, 14'd100);
        checks++;
        if (s[0] != e) begin
            errors++;
            $display("FAIL b2b_str got %s exp %s", vis(s[0]), vis(e));
        end
        checks++;
        if (ndrop[0] !== 1) begin
            errors++;
            $display("FAIL b2b_drop got %0d exp 1", ndrop[0]);
        end
        checks++;
        if (rise[0][1] !== 42 || ndone[0] !== 2) begin
            errors++;
            $display("FAIL b2b_second got r%0d n%0d exp r42 n2",
                rise[0][1], ndone[0]);
        end
        checks++;
        if (btr[27] !== 1'b0 || btr[28] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle got %b%b exp 01",
                btr[27], btr[28]);
        end
    endtask

    task automatic test_timer;
        run_cycles(650, 1'b0, -1, -1, -1, -1, 14'd0);
        checks++;
        if (nrise[4] < 3) begin
            errors++;
            $display("FAIL timer_count got %0d exp >=3", nrise[4]);
        end
        checks++;
        if (rise[4][1] - rise[4][0] !== 200 ||
            rise[4][2] - rise[4][1] !== 200) begin
            errors++;
            $display("FAIL timer_period got %0d %0d exp 200 200",
                rise[4][1] - rise[4][0], rise[4][2] - rise[4][1]);
        end
        checks++;
        if (ndone[0] !== 0) begin
            errors++;
            $display("FAIL timer_idle got %0d exp 0", ndone[0]);
        end
    endtask

    task automatic test_reset_mid;
        string e;
        e = {"temp:0.00", CRLF};
        load(14'd2537, 1'b0);
        run_cycles(20, 1'b0, 0, -1, -1, -1, 14'd0);
        #1;
        checks++;
        if (bv[0] !== 1'b1 || bd[0] !== 8'h32) begin
            errors++;
            $display("FAIL rmid_pre got v%b d%h exp v1 d32",
                bv[0], bd[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bv[0], bsy[0], fd[0]} !== 3'b000 || bd[0] !== 8'h00) begin
            errors++;
            $display("FAIL rmid_abort got %b d%h exp 000 d00",
                {bv[0], bsy[0], fd[0]}, bd[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        run_cycles(40, 1'b0, -1, -1, -1, -1, 14'd0);
        checks++;
        if (s[0] != "" || nrise[0] !== 0) begin
            errors++;
            $display("FAIL rmid_quiet got %s r%0d exp empty r0",
                vis(s[0]), nrise[0]);
        end
        run_cycles(40, 1'b0, 0, -1, -1, -1, 14'd0);
        checks++;
        if (s[0] != e || rise[0][0] !== 15) begin
            errors++;
            $display("FAIL rmid_fresh got %s r%0d exp %s r15",
                vis(s[0]), rise[0][0], vis(e));
        end
    endtask

    initial begin
        rst = 1'b1;
        td  = '0;
        ts  = 1'b0;
        tv  = 1'b0;
        tg  = 1'b0;
        br  = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        test_default;
        test_negative;
        test_saturate;
        test_no_frac;
        test_stall;
        test_back_to_back;
        test_timer;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_report_framer.md
Name: temp_report_framer

Overview:
Parametrised successor to the fixed one-per-second temperature-to-UART text formatter. Converts a signed-magnitude fixed-point temperature sample into an ASCII report frame such as "temp:-25.37\r\n", using a sequential double-dabble binary-to-BCD converter. It emits bytes over a valid/ready byte stream into the TX FIFO/UART path. Frames are triggered by an internal period timer or an external request. Integer/fraction digit counts, leading-zero suppression and line terminator are configurable.

Parameters:
REPORT_CYC, 50000000, period timer length in sys_clk cycles (1 s at 50 MHz); minimum 2
DATA_W, 14, width of temperature magnitude input
INT_DIGITS, 3, integer digits printed (1..4)
FRAC_DIGITS, 2, fraction digits printed (0..3); input is magnitude x 10^FRAC_DIGITS
LZ_SUPPRESS, 1, 1 = suppress leading integer zeros (units digit always printed)
APPEND_CRLF, 1, 1 = append 0x0D 0x0A after last digit

Ports:
sys_clk    in   1       system clock
sys_rst    in   1       asynchronous reset, active-high
temp_data  in   DATA_W  temperature magnitude, scaled by 10^FRAC_DIGITS
temp_sign  in   1       1 = negative
temp_valid in   1       single-cycle strobe; latch temp_data/temp_sign into held sample
trig       in   1       single-cycle manual report request
byte_data  out  8       ASCII byte
byte_valid out  1       byte_data valid
byte_ready in   1       sink accepts byte (transfer = byte_valid & byte_ready)
busy       out  1       frame in progress (any state except IDLE)
frame_done out  1       one-cycle pulse on transfer of last byte of frame
sat        out  1       one-cycle pulse at end of CONV if value saturated
trig_drop  out  1       one-cycle pulse when a trigger is discarded

Behaviour:
- Reset: all outputs 0. Held sample = 0, sign 0. Timer = 0, pending = 0, state IDLE. Async assertion mid-frame aborts immediately; no partial-frame resume.
- Held sample: updated on every temp_valid, including during a frame. The frame uses a snapshot taken on the cycle CONV is entered.
- Timer: free-running 0..REPORT_CYC-1 and independent of busy. Wrap generates an internal trigger.
- Triggers (timer wrap OR trig; simultaneous = one trigger):
  - In IDLE: enter CONV next cycle.
  - When busy and pending=0: set pending.
  - When busy and pending=1: pulse trig_drop.
  - At frame end, pending=1 means IDLE lasts exactly one cycle, then CONV; pending clears on CONV entry.
- States: IDLE -> CONV -> PRE -> [SIGN] -> INT -> [DOT -> FRAC] -> [EOL] -> IDLE.
  - CONV: shift-add-3 double-dabble over D=INT_DIGITS+FRAC_DIGITS BCD digits, exactly DATA_W cycles. Saturation: if snapshot >= 10^D, every digit = 9 and sat pulses on the last CONV cycle.
  - PRE: "temp:" (0x74 0x65 0x6D 0x70 0x3A).
  - SIGN: '-' (0x2D), only if snapshot sign=1. No byte for positive values; negative zero still prints '-'.
  - INT: integer digits MSB first as 0x30+digit. With LZ_SUPPRESS, skip leading zeros with no idle cycle; the units digit is always sent.
  - DOT/FRAC: '.' (0x2E) then fraction digits, only when FRAC_DIGITS>0.
  - EOL: 0x0D 0x0A, only when APPEND_CRLF=1.
- Handshake:
  - byte_valid asserts in the first cycle of PRE.
  - While byte_valid & !byte_ready, byte_data and byte_valid hold stable.
  - Next byte is presented the cycle after a transfer, so with byte_ready tied high throughput is one byte per clock.
  - byte_valid never drops without a transfer (except reset).
- Latency: trigger sampled in IDLE at cycle T gives CONV in T+1..T+DATA_W and first byte_valid at T+DATA_W+1.
- frame_done is coincident with the transfer of the final byte. busy deasserts the following cycle.

Test Plan:
- Defaults, temp_valid with 2537/sign 0, trig, byte_ready=1 -> bytes "temp:25.37\r\n" (12 bytes), consecutive cycles, first byte_valid 15 cycles after trig, frame_done on 0x0A.
- temp_data=5, sign=1 -> "temp:-0.05\r\n". Repeat with LZ_SUPPRESS=0 -> "temp:-000.05\r\n".
- INT_DIGITS=2, temp_data=16383 -> "temp:99.99\r\n" with one sat pulse. FRAC_DIGITS=0, APPEND_CRLF=0, 42 -> "temp:42" with no '.'.
- byte_ready toggling 1-of-3 cycles -> byte_data stable during stalls, identical byte sequence, no lost/duplicated bytes.
- Three trig pulses during one frame -> second frame starts one idle cycle after frame_done, exactly one trig_drop pulse. temp_valid with 100 mid-frame -> current frame unchanged, next frame prints "temp:1.00".
- REPORT_CYC=200 -> frames start every 200 cycles. sys_rst pulsed mid-INT -> outputs 0 immediately, no further bytes until next trigger, next frame starts fresh at "t".
